// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external ALU between two requesters.
//
// Each operation runs IDLE -> EXEC -> RESP -> IDLE. In IDLE, one pending requester is
// granted through a combinational reqN_ready. Its operands are latched and driven to the
// ALU. The result is captured after WAIT_CYCLES cycles of EXEC. It is then held on resp_*
// until the winner's response handshake completes.
//
// Configuration macro: ALU_ARB_RR_EN
//   defined   -> round-robin arbitration; the pointer names the preferred requester.
//   undefined -> fixed priority; requester 0 wins ties.
//
// Parameters:
//   WAIT_CYCLES  ALU settle cycles spent in EXEC before capture (legal 1..15)
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req0_*/req1_*                 request handshake (valid/ready) plus a, b, aluc operands
//   resp0_valid/resp1_valid       result available for requester N
//   resp0_ready/resp1_ready       requester N takes the result
//   resp_r, resp_zero/carry/negative/overflow   shared registered result and flags
//   alu_a, alu_b, alu_aluc        latched operands driven to the shared ALU
//   alu_r, alu_zero/carry/negative/overflow     combinational ALU result
//   busy                          arbiter is not idle
//   op_cnt                        completed operations (wraps at 16 bits)
module alu_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_aluc,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_aluc,

    output logic        resp0_valid,
    input  logic        resp0_ready,
    output logic        resp1_valid,
    input  logic        resp1_ready,

    output logic [31:0] resp_r,
    output logic        resp_zero,
    output logic        resp_carry,
    output logic        resp_negative,
    output logic        resp_overflow,

    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_aluc,
    input  logic [31:0] alu_r,
    input  logic        alu_zero,
    input  logic        alu_carry,
    input  logic        alu_negative,
    input  logic        alu_overflow,

    output logic        busy,
    output logic [15:0] op_cnt
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

    // Counter value on the last EXEC cycle.
    localparam logic [3:0] LastCnt = 4'(WAIT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [3:0]  aluc_q, aluc_d;
    logic        win_q, win_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] r_q, r_d;
    logic        zero_q, zero_d;
    logic        carry_q, carry_d;
    logic        neg_q, neg_d;
    logic        ovf_q, ovf_d;
    logic [15:0] op_cnt_q, op_cnt_d;

    logic        any_req;
    logic        pick;
    logic        resp_hs;

    // Carry is meaningful only for add/sub-unsigned and the shift opcodes.
    function automatic logic carry_kept(input logic [3:0] op);
        return op inside {4'b0000, 4'b0001, 4'b1100, 4'b1101, 4'b1110, 4'b1111};
    endfunction

    // Overflow is meaningful only for signed add/sub and signed compare.
    function automatic logic ovf_kept(input logic [3:0] op);
        return op inside {4'b0010, 4'b0011, 4'b1011};
    endfunction

    // ---------------------------------------------------------------------------------
    // Winner selection. pick = 1 means requester 1 wins. A lone request always wins.
    // ---------------------------------------------------------------------------------
`ifdef ALU_ARB_RR_EN
    logic ptr_q, ptr_d;

    always_comb begin
        any_req = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            pick = ptr_q;
        end else begin
            pick = ~req0_valid;
        end
    end
`else
    always_comb begin
        any_req = req0_valid | req1_valid;
        pick    = ~req0_valid;
    end
`endif

    // ---------------------------------------------------------------------------------
    // Next-state and output logic
    // ---------------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        aluc_d     = aluc_q;
        win_d      = win_q;
        cnt_d      = cnt_q;
        r_d        = r_q;
        zero_d     = zero_q;
        carry_d    = carry_q;
        neg_d      = neg_q;
        ovf_d      = ovf_q;
        op_cnt_d   = op_cnt_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        // The non-winner's resp ready is never looked at.
        resp_hs    = win_q ? resp1_ready : resp0_ready;
`ifdef ALU_ARB_RR_EN
        ptr_d      = ptr_q;
`endif

        case (state_q)
            StIdle: begin
                if (any_req) begin
                    req0_ready = ~pick;
                    req1_ready = pick;
                    a_d        = pick ? req1_a    : req0_a;
                    b_d        = pick ? req1_b    : req0_b;
                    aluc_d     = pick ? req1_aluc : req0_aluc;
                    win_d      = pick;
                    cnt_d      = 4'd0;
                    state_d    = StExec;
                end
            end

            StExec: begin
                if (cnt_q == LastCnt) begin
                    r_d     = alu_r;
                    zero_d  = alu_zero;
                    carry_d = alu_carry & carry_kept(aluc_q);
                    neg_d   = alu_negative;
                    ovf_d   = alu_overflow & ovf_kept(aluc_q);
                    cnt_d   = 4'd0;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            StResp: begin
                if (resp_hs) begin
                    op_cnt_d = op_cnt_q + 16'd1;
                    state_d  = StIdle;
`ifdef ALU_ARB_RR_EN
                    // Prefer the requester that lost this round.
                    ptr_d    = ~win_q;
`endif
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ---------------------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            aluc_q   <= 4'd0;
            win_q    <= 1'b0;
            cnt_q    <= 4'd0;
            r_q      <= 32'd0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            op_cnt_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluc_q   <= aluc_d;
            win_q    <= win_d;
            cnt_q    <= cnt_d;
            r_q      <= r_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            op_cnt_q <= op_cnt_d;
        end
    end

`ifdef ALU_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // ---------------------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------------------
    always_comb begin
        resp0_valid   = (state_q == StResp) && !win_q;
        resp1_valid   = (state_q == StResp) &&  win_q;
        resp_r        = r_q;
        resp_zero     = zero_q;
        resp_carry    = carry_q;
        resp_negative = neg_q;
        resp_overflow = ovf_q;
        alu_a         = a_q;
        alu_b         = b_q;
        alu_aluc      = aluc_q;
        busy          = (state_q != StIdle);
        op_cnt        = op_cnt_q;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: WAIT_CYCLES, 1, ALU settle cycles spent in EXEC before capture (legal 1..15).
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: req0_valid / req1_valid  input  1  requester N has an operation pending.
REQ-005 SHALL have ports: req0_ready / req1_ready  output  1  arbiter accepts requester N this cycle.
REQ-006 SHALL have ports: req0_a, req0_b, req1_a, req1_b  input  32  operands; req0_aluc, req1_aluc  input  4  ALU opcode.
REQ-007 SHALL have ports: resp0_valid / resp1_valid  output  1  result for requester N available; resp0_ready / resp1_ready  input  1  requester N takes result.
REQ-008 SHALL have ports: resp_r  output  32  result; resp_zero, resp_carry, resp_negative, resp_overflow  output  1  flags (shared by both responders).
REQ-009 SHALL have ports: alu_a, alu_b  output  32, alu_aluc  output  4  drive to shared ALU; alu_r  input  32, alu_zero, alu_carry, alu_negative, alu_overflow  input  1  from ALU.
REQ-010 SHALL have ports: busy  output  1  state is not IDLE; op_cnt  output  16  completed operations.

Function
REQ-011 SHALL implement states IDLE, EXEC, RESP.
REQ-012 IDLE: if any reqN_valid, SHALL select a winner, assert only winner's reqN_ready combinationally in that cycle, latch its a/b/aluc and winner id, go EXEC next edge.
REQ-013 reqN_ready SHALL be 0 in EXEC and RESP and for the loser in IDLE.
REQ-014 alu_a/alu_b/alu_aluc SHALL always drive the latched operands (hold between operations).
REQ-015 EXEC SHALL last exactly WAIT_CYCLES cycles (internal counter); on the last EXEC edge SHALL register alu_r and flags into resp_* and go RESP.
REQ-016 Flag masking: resp_carry SHALL be forced 0 unless aluc in {0000,0001,1100,1101,1110,1111}; resp_overflow forced 0 unless aluc in {0010,0011,1011}; no X/Z reaches resp_*.
REQ-017 RESP: respN_valid SHALL be 1 only for latched winner; resp_* SHALL be stable until handshake.
REQ-018 On respN_valid && respN_ready SHALL go IDLE next edge, increment op_cnt (wraps 0xFFFF->0x0000), update arbitration pointer.
REQ-019 Latency: request accepted in cycle T SHALL yield respN_valid first in cycle T+1+WAIT_CYCLES; max throughput one op per WAIT_CYCLES+2 cycles.
REQ-020 The ready signal of the non-winner's response port SHALL be ignored; reqN_valid changes outside IDLE SHALL be ignored.
REQ-021 Simultaneous requests SHALL be resolved per REQ-026; a lone request SHALL always win regardless of pointer.

Reset
REQ-022 rst high SHALL immediately force: state IDLE, latched a/b/aluc 0 (alu_* = 0), resp_* 0, respN_valid 0, op_cnt 0, arbitration pointer = requester 0, EXEC counter 0.
REQ-023 Reset mid-EXEC or mid-RESP SHALL abandon the operation with no response and no op_cnt increment.
REQ-024 First active edge after rst deasserts SHALL evaluate IDLE normally.

Configuration
REQ-025 Macro ALU_ARB_RR_EN SHALL select the arbitration policy.
REQ-026 Defined: round-robin; pointer names the preferred requester, set to the non-winner after each response handshake. Undefined: fixed priority, requester 0 always wins ties; pointer unused.

Verification
REQ-027 Reset then req0: a=5,b=3,aluc=0000, WAIT_CYCLES=1 -> req0_ready cycle T, resp0_valid cycle T+2, resp_r=8, zero=0, carry=0, op_cnt=1 after handshake.
REQ-028 req1: a=0x7FFFFFFF,b=1,aluc=0010 -> resp_r=0x80000000, overflow=1, negative=1, carry=0 (masked).
REQ-029 Both valid continuously, RR_EN defined -> grant order 0,1,0,1; undefined -> 0,0,0,0 with req1 starved.
REQ-030 resp0_ready held low 10 cycles in RESP -> resp0_valid and resp_* stable, req*_ready 0, busy 1 throughout.
REQ-031 rst asserted in EXEC of a sub op -> next cycle resp*_valid 0, alu_a=0, op_cnt unchanged; new request after release completes normally.
REQ-032 Preload op_cnt 0xFFFF via 65535 ops (or force) then one op -> op_cnt=0x0000.
